// File: rtl/prco_lmem_arb_pkg.sv
// prco_lmem_arb_pkg: shared state/requester encodings, default depth and helpers for the local-memory arbiter
package prco_lmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } req_id_t;

    localparam int unsigned LMEM_DEPTH_DEFAULT = 255;

    function automatic logic addr_err(input logic [15:0] addr, input int unsigned depth);
        return {16'd0, addr} > depth;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
        return (inc && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    endfunction

endpackage

// File: rtl/prco_lmem_arb_if.sv
// prco_lmem_arb_if: fetch, data and memory-pin bundle of the local-memory arbiter
interface prco_lmem_arb_if;

    logic        i_fetch_req;
    logic [15:0] i_fetch_addr;
    logic        q_fetch_done;
    logic [15:0] q_fetch_data;
    logic        q_fetch_err;

    logic        i_data_req;
    logic        i_data_we;
    logic [15:0] i_data_addr;
    logic [15:0] i_data_wdata;
    logic        q_data_done;
    logic [15:0] q_data_rdata;
    logic        q_data_err;

    logic        q_mem_ce;
    logic        q_mem_we;
    logic [15:0] q_mem_addr;
    logic [15:0] q_mem_dina;
    logic [15:0] i_mem_douta;

    modport slave (
        input  i_fetch_req, i_fetch_addr,
        output q_fetch_done, q_fetch_data, q_fetch_err,
        input  i_data_req, i_data_we, i_data_addr, i_data_wdata,
        output q_data_done, q_data_rdata, q_data_err,
        output q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
        input  i_mem_douta
    );

    modport master (
        output i_fetch_req, i_fetch_addr,
        input  q_fetch_done, q_fetch_data, q_fetch_err,
        output i_data_req, i_data_we, i_data_addr, i_data_wdata,
        input  q_data_done, q_data_rdata, q_data_err,
        input  q_mem_ce, q_mem_we, q_mem_addr, q_mem_dina,
        output i_mem_douta
    );

endinterface

// File: rtl/prco_lmem_arb_stats.sv
// prco_lmem_arb_stats: saturating completion and stall counters; clear beats increment
module prco_lmem_arb_stats
    import prco_lmem_arb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clr,
    input  logic        i_fetch_inc,
    input  logic        i_data_inc,
    input  logic        i_stall_inc,
    output logic [15:0] q_fetch_cnt,
    output logic [15:0] q_data_cnt,
    output logic [15:0] q_stall_cnt
);

    // count events, sticking at all-ones
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || i_clr) begin
            q_fetch_cnt <= '0;
            q_data_cnt  <= '0;
            q_stall_cnt <= '0;
        end else begin
            q_fetch_cnt <= sat_inc(q_fetch_cnt, i_fetch_inc);
            q_data_cnt  <= sat_inc(q_data_cnt, i_data_inc);
            q_stall_cnt <= sat_inc(q_stall_cnt, i_stall_inc);
        end
    end

endmodule

// File: rtl/prco_lmem_arb.sv
// prco_lmem_arb: round-robin fetch/data arbiter sequencing the single-port local memory; PRCO_LMEM_ARB_STATS_EN adds counters
module prco_lmem_arb
    import prco_lmem_arb_pkg::*;
#(
    parameter int unsigned P_LMEM_DEPTH = LMEM_DEPTH_DEFAULT,
    parameter bit          P_RR_INIT    = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_reset,
    prco_lmem_arb_if.slave bus
`ifdef PRCO_LMEM_ARB_STATS_EN
    ,
    input  logic           i_stat_clr,
    output logic [15:0]    q_stat_fetch_cnt,
    output logic [15:0]    q_stat_data_cnt,
    output logic [15:0]    q_stat_stall_cnt
`endif
);

    state_t      state, state_nx;
    req_id_t     id, grant_id;
    logic        rr, err, grant, fetch_req, data_req, g_err;
    logic [15:0] g_addr;
    logic        fetch_done, data_done, fetch_err, data_err, mem_ce, mem_we;
    logic [15:0] fetch_data, data_rdata, mem_addr, mem_dina;

    // grant selection and next state; a requester is ignored during its own done cycle so a held request is not re-issued
    always_comb begin
        fetch_req = bus.i_fetch_req & ~fetch_done;
        data_req  = bus.i_data_req & ~data_done;
        grant     = (state == IDLE) & (fetch_req | data_req);
        grant_id  = (fetch_req & data_req) ? req_id_t'(rr) : (data_req ? DATA : FETCH);
        g_addr    = (grant_id == DATA) ? bus.i_data_addr : bus.i_fetch_addr;
        g_err     = addr_err(g_addr, P_LMEM_DEPTH);
        state_nx  = (state == IDLE) ? (grant ? ACCESS : IDLE) : (state == ACCESS) ? CAPTURE : IDLE;
    end

    // state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    // latch the granted transaction, drive the memory pins for one cycle and return data with a done pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rr         <= P_RR_INIT;
            id         <= FETCH;
            err        <= 1'b0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_dina   <= '0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            fetch_data <= '0;
            data_done  <= 1'b0;
            data_err   <= 1'b0;
            data_rdata <= '0;
        end else begin
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            data_done  <= 1'b0;
            data_err   <= 1'b0;
            if (grant) begin
                id       <= grant_id;
                err      <= g_err;
                mem_addr <= g_addr;
                mem_dina <= (grant_id == DATA) ? bus.i_data_wdata : '0;
                mem_ce   <= ~g_err;
                mem_we   <= (grant_id == DATA) & bus.i_data_we & ~g_err;
                if (fetch_req & data_req) rr <= ~rr;
            end
            if (state == CAPTURE) begin
                if (id == DATA) begin
                    data_done  <= 1'b1;
                    data_err   <= err;
                    data_rdata <= err ? '0 : bus.i_mem_douta;
                end else begin
                    fetch_done <= 1'b1;
                    fetch_err  <= err;
                    fetch_data <= err ? '0 : bus.i_mem_douta;
                end
            end
        end
    end

    assign bus.q_fetch_done = fetch_done;
    assign bus.q_fetch_err  = fetch_err;
    assign bus.q_fetch_data = fetch_data;
    assign bus.q_data_done  = data_done;
    assign bus.q_data_err   = data_err;
    assign bus.q_data_rdata = data_rdata;
    assign bus.q_mem_ce     = mem_ce;
    assign bus.q_mem_we     = mem_we;
    assign bus.q_mem_addr   = mem_addr;
    assign bus.q_mem_dina   = mem_dina;

`ifdef PRCO_LMEM_ARB_STATS_EN
    logic fetch_wait, data_wait;

    assign fetch_wait = fetch_req & ~(grant & (grant_id == FETCH)) & ~((state != IDLE) & (id == FETCH));
    assign data_wait  = data_req & ~(grant & (grant_id == DATA)) & ~((state != IDLE) & (id == DATA));

    prco_lmem_arb_stats u_stats (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clr       (i_stat_clr),
        .i_fetch_inc (fetch_done),
        .i_data_inc  (data_done),
        .i_stall_inc (fetch_wait | data_wait),
        .q_fetch_cnt (q_stat_fetch_cnt),
        .q_data_cnt  (q_stat_data_cnt),
        .q_stall_cnt (q_stat_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_prco_lmem_arb.sv
// tb_prco_lmem_arb: directed stimulus with scoreboard queues checked by a negedge monitor
module tb_prco_lmem_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   f_cnt = 0;

    always #5 clk = ~clk;

    prco_lmem_arb_if bus ();

`ifdef PRCO_LMEM_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] s_fetch, s_data, s_stall;
`endif

    prco_lmem_arb #(.P_LMEM_DEPTH(255), .P_RR_INIT(1'b0)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
`ifdef PRCO_LMEM_ARB_STATS_EN
        ,
        .i_stat_clr       (stat_clr),
        .q_stat_fetch_cnt (s_fetch),
        .q_stat_data_cnt  (s_data),
        .q_stat_stall_cnt (s_stall)
`endif
    );

    typedef struct packed {logic [15:0] d; logic e;} rsp_t;
    typedef struct packed {logic we; logic [15:0] a; logic [15:0] w;} acc_t;
    rsp_t exp_f[$];
    rsp_t exp_d[$];
    acc_t exp_m[$];

    logic [15:0] mem [256];

    // registered-read, read-first memory model
    always @(posedge clk) begin
        if (bus.q_mem_ce) begin
            bus.i_mem_douta <= mem[bus.q_mem_addr[7:0]];
            if (bus.q_mem_we) mem[bus.q_mem_addr[7:0]] <= bus.q_mem_dina;
        end
    end

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: pop the scoreboard whenever the DUT presents a done or a memory access
    always @(negedge clk) begin
        rsp_t r;
        acc_t m;
        if (!rst) begin
            if (bus.q_fetch_done) begin
                f_cnt++;
                if (exp_f.size() == 0) chk("fetch_spurious_done", 32'(bus.q_fetch_done), 0);
                else begin
                    r = exp_f.pop_front();
                    chk("fetch_data", 32'(bus.q_fetch_data), 32'(r.d));
                    chk("fetch_err", 32'(bus.q_fetch_err), 32'(r.e));
                end
            end
            if (bus.q_data_done) begin
                if (exp_d.size() == 0) chk("data_spurious_done", 32'(bus.q_data_done), 0);
                else begin
                    r = exp_d.pop_front();
                    chk("data_rdata", 32'(bus.q_data_rdata), 32'(r.d));
                    chk("data_err", 32'(bus.q_data_err), 32'(r.e));
                end
            end
            if (bus.q_mem_ce) begin
                if (exp_m.size() == 0) chk("mem_spurious_ce", 32'(bus.q_mem_ce), 0);
                else begin
                    m = exp_m.pop_front();
                    chk("mem_we", 32'(bus.q_mem_we), 32'(m.we));
                    chk("mem_addr", 32'(bus.q_mem_addr), 32'(m.a));
                    if (m.we) chk("mem_dina", 32'(bus.q_mem_dina), 32'(m.w));
                end
            end
            if (bus.q_mem_we && !bus.q_mem_ce) chk("we_without_ce", 32'(bus.q_mem_we), 0);
        end
    end

    task automatic do_fetch(input logic [15:0] a, input logic [15:0] ed, input logic ee, input int lat_exp);
        int lat;
        exp_f.push_back('{d: ed, e: ee});
        if (!ee) exp_m.push_back('{we: 1'b0, a: a, w: 16'h0});
        bus.i_fetch_addr = a;
        bus.i_fetch_req  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.q_fetch_done && lat < 20);
        chk("fetch_latency", lat, lat_exp);
        bus.i_fetch_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_data(input logic [15:0] a, input logic we, input logic [15:0] w,
                           input logic [15:0] ed, input logic ee, input int lat_exp);
        int lat;
        exp_d.push_back('{d: ed, e: ee});
        if (!ee) exp_m.push_back('{we: we, a: a, w: w});
        bus.i_data_addr  = a;
        bus.i_data_we    = we;
        bus.i_data_wdata = w;
        bus.i_data_req   = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.q_data_done && lat < 20);
        chk("data_latency", lat, lat_exp);
        bus.i_data_req   = 1'b0;
        bus.i_data_we    = 1'b0;
        bus.i_data_wdata = 16'h0;
        @(negedge clk);
    endtask

    initial begin
        int fd[2];
        int dd[2];
        int fs, ds, saved;
        bus.i_fetch_req  = 1'b0;
        bus.i_fetch_addr = 16'h0;
        bus.i_data_req   = 1'b0;
        bus.i_data_we    = 1'b0;
        bus.i_data_addr  = 16'h0;
        bus.i_data_wdata = 16'h0;
        mem[8'h04] = 16'h24AB;
        mem[8'hAB] = 16'h1111;
        mem[8'h10] = 16'hF010;
        mem[8'h20] = 16'hD020;
        mem[8'hFF] = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({bus.q_fetch_done, bus.q_data_done, bus.q_mem_ce, bus.q_mem_we, bus.q_fetch_err, bus.q_data_err}), 0);
        chk("rst_fetch_data", 32'(bus.q_fetch_data), 0);
        chk("rst_data_rdata", 32'(bus.q_data_rdata), 0);
        chk("rst_mem_bus", {bus.q_mem_addr, bus.q_mem_dina}, 0);
        rst = 1'b0;
        @(negedge clk);

        // contention from reset: both held, order fetch, data, fetch, data, 3 cycles apart
        exp_m.push_back('{we: 1'b0, a: 16'h0010, w: 16'h0});
        exp_m.push_back('{we: 1'b0, a: 16'h0020, w: 16'h0});
        exp_m.push_back('{we: 1'b0, a: 16'h0010, w: 16'h0});
        exp_m.push_back('{we: 1'b0, a: 16'h0020, w: 16'h0});
        repeat (2) exp_f.push_back('{d: 16'hF010, e: 1'b0});
        repeat (2) exp_d.push_back('{d: 16'hD020, e: 1'b0});
        bus.i_fetch_addr = 16'h0010;
        bus.i_data_addr  = 16'h0020;
        bus.i_fetch_req  = 1'b1;
        bus.i_data_req   = 1'b1;
        fs = 0;
        ds = 0;
        fd = '{0, 0};
        dd = '{0, 0};
        for (int i = 1; i <= 40 && (fs < 2 || ds < 2); i++) begin
            @(negedge clk);
            if (bus.q_fetch_done && fs < 2) begin
                fd[fs] = i;
                fs++;
                if (fs == 2) bus.i_fetch_req = 1'b0;
            end
            if (bus.q_data_done && ds < 2) begin
                dd[ds] = i;
                ds++;
                if (ds == 2) bus.i_data_req = 1'b0;
            end
        end
        chk("rr_fetch0_cycle", fd[0], 3);
        chk("rr_data0_cycle", dd[0], 6);
        chk("rr_fetch1_cycle", fd[1], 9);
        chk("rr_data1_cycle", dd[1], 12);
        @(negedge clk);

        // single fetch and data write/read
        do_fetch(16'h0004, 16'h24AB, 1'b0, 3);
        do_data(16'h00AB, 1'b1, 16'hCAFE, 16'h1111, 1'b0, 3);
        do_data(16'h00AB, 1'b0, 16'h0000, 16'hCAFE, 1'b0, 3);

        // range boundaries
        do_data(16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b1, 3);
        do_data(16'h00FF, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 3);
        do_fetch(16'hFFFF, 16'h0000, 1'b1, 3);
        do_data(16'h0100, 1'b1, 16'h1234, 16'h0000, 1'b1, 3);
        do_fetch(16'h00FF, 16'hBEEF, 1'b0, 3);

        // reset during ACCESS drops the transaction
        exp_m.push_back('{we: 1'b0, a: 16'h0004, w: 16'h0});
        bus.i_fetch_addr = 16'h0004;
        bus.i_fetch_req  = 1'b1;
        @(negedge clk);
        chk("mid_access_ce", 32'(bus.q_mem_ce), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", 32'({bus.q_fetch_done, bus.q_data_done, bus.q_mem_ce, bus.q_mem_we, bus.q_fetch_err, bus.q_data_err}), 0);
        chk("mid_rst_data", {bus.q_fetch_data, bus.q_data_rdata}, 0);
        chk("mid_rst_mem", {bus.q_mem_addr, bus.q_mem_dina}, 0);
        bus.i_fetch_req = 1'b0;
        saved = f_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_done_after_reset", f_cnt, saved);
        do_fetch(16'h0004, 16'h24AB, 1'b0, 3);

`ifdef PRCO_LMEM_ARB_STATS_EN
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        fork
            do_fetch(16'h0004, 16'h24AB, 1'b0, 3);
            begin
                #1 do_data(16'h0020, 1'b0, 16'h0000, 16'hD020, 1'b0, 6);
            end
        join
        do_fetch(16'h0004, 16'h24AB, 1'b0, 3);
        repeat (3) @(negedge clk);
        chk("stat_fetch_cnt", 32'(s_fetch), 2);
        chk("stat_data_cnt", 32'(s_data), 1);
        chk("stat_stall_cnt", 32'(s_stall), 3);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_clr", {s_fetch, s_data} | 32'(s_stall), 0);
`endif

        repeat (3) @(negedge clk);
        chk("fetch_queue_drained", exp_f.size(), 0);
        chk("data_queue_drained", exp_d.size(), 0);
        chk("mem_queue_drained", exp_m.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
